timer_unit: RTL
===============

// Module: timer_unit
// PURPOSE
//  Parametrised multi-channel timer peripheral on the CPU data bus (STB/ACK slave).
//  A shared prescaler divides clk into a tick; a free-running tick counter and N_CH
//  down-counting channels (one-shot or auto-reload) run from it. Expiry sets sticky
//  per-channel flags that are readable and W1C-clearable, plus a maskable IRQ line.
// PARAMETERS
//  TICK_DIV  100000  clk cycles per tick (>=2); 1 ms at 100 MHz
//  N_CH      3       number of timer channels, 1..8
//  CNT_W     32      channel LOAD/CNT width, 1..32; zero-extended on reads
// PORTS
//  clk    in   1      system clock, all state on rising edge
//  reset  in   1      asynchronous, active-high
//  STB    in   1      bus strobe, held by master until ACK
//  WE     in   1      1 = write, 0 = read; sampled with STB
//  ADR    in   5      word address
//  DAT_I  in   32     write data
//  DAT_O  out  32     read data, valid while ACK=1
//  ACK    out  1      registered acknowledge
//  IRQ    out  1      registered, |(FLAG & IE)
// BEHAVIOUR
//  Reset: every register, prescaler, ACK, DAT_O and IRQ = 0. Reset mid-count aborts all.
//  Prescaler: pre counts 0..TICK_DIV-1 and wraps; tick=1 for the cycle pre==TICK_DIV-1.
//  Bus: access cycle = STB & ~ACK. Writes commit at that edge. ACK=1 the next cycle,
//   DAT_O = read value sampled at the access edge. ACK is held one cycle, so a held
//   STB gets a new access every 2 cycles. Latency 1 cycle.
//   DAT_O = 0 whenever ACK=0 and for unmapped/reserved addresses.
//  Register map (word address):
//   0 STATUS  [N_CH-1:0] FLAG; read; write 1 clears bit (W1C), write 0 no effect
//   1 CTRL    [7:0] EN, [15:8] AUTO, [23:16] IE; bits >= N_CH in each field read 0
//   2 TICKS   32-bit free-running tick count, +1 per tick, wraps FFFFFFFF->0; writable
//   3 reserved: reads 0, writes ignored
//   4+2i LOAD[i]; 5+2i CNT[i] (i<N_CH); writes truncated to CNT_W
//   Addresses >= 4+2*N_CH are unmapped.
//  Channel i, on tick with EN[i]=1:
//   CNT>1  -> CNT-1
//   CNT<=1 -> expire:
//     FLAG[i] <= 1
//     AUTO[i]=1: CNT <= LOAD (period = LOAD ticks; LOAD 0 or 1 expires every tick)
//     AUTO[i]=0: CNT <= 0, EN[i] <= 0
//   EN[i]=0: CNT holds.
//  Writing LOAD does not touch CNT. Software starts a channel by writing CNT, then EN.
//  Simultaneous events, same edge:
//   bus write to CNT[i] vs tick   -> bus value wins, decrement/expiry lost
//   CTRL write vs one-shot clear  -> written EN wins, FLAG still set
//   W1C vs expiry of same channel -> FLAG stays 1, set wins
//   TICKS write vs tick           -> written value wins
//  IRQ registered: updates the cycle after FLAG/IE change.
// TESTING (bench TICK_DIV=4, N_CH=3, CNT_W=16)
//  1 Reset then read TICKS after 10 clk  -> 2. Assert reset mid-count -> all reads 0,
//    IRQ=0, prescaler restarts from 0.
//  2 LOAD0=3, CNT0=3, CTRL=0x010101 (EN0, AUTO0, IE0) -> FLAG0 and IRQ rise every
//    12 clk after first expiry; W1C 0x1 -> IRQ drops the next cycle.
//  3 CNT1=2, CTRL EN1 only (one-shot) -> after 2 ticks FLAG1=1, CTRL reads EN1=0,
//    CNT1 stays 0 for further ticks.
//  4 Write STATUS=0x1 on the exact expiry edge of channel 0 -> FLAG0 reads 1.
//  5 Write TICKS=0xFFFFFFFF -> after one tick reads 0x00000000.
//    Write CNT2=0x12345 -> reads 0x2345.
//  6 Bus timing: STB rises -> ACK exactly 1 cycle later for 1 cycle, DAT_O valid then.
//    Read/write ADR 3 and ADR 12 -> read 0, no state change.
//    Held STB -> ACK every 2nd cycle.

Source files
------------

// File: rtl/timer_unit_if.sv
// ----------------------------------------------------------------------------
// timer_unit_if
// Bus bundle between the CPU data bus (master) and the timer peripheral (slave).
// Signals:
//   STB    master->slave  strobe, held until ACK
//   WE     master->slave  1 = write, 0 = read
//   ADR    master->slave  5-bit word address
//   DAT_I  master->slave  32-bit write data
//   DAT_O  slave->master  32-bit read data, valid while ACK = 1
//   ACK    slave->master  registered acknowledge
// ----------------------------------------------------------------------------
interface timer_unit_if;
    logic        STB;
    logic        WE;
    logic [4:0]  ADR;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;

    modport master (output STB, WE, ADR, DAT_I, input DAT_O, ACK);
    modport slave  (input STB, WE, ADR, DAT_I, output DAT_O, ACK);
endinterface

// File: rtl/timer_unit.sv
// ----------------------------------------------------------------------------
// timer_unit
// Multi-channel timer peripheral. A shared prescaler divides clk into a tick.
// A free-running 32-bit tick counter and N_CH down-counting channels (one-shot
// or auto-reload) advance on that tick. Expiry sets sticky W1C flags, and a
// registered IRQ reports any flag whose interrupt enable is set.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high
//   bus    slave modport of timer_unit_if (STB/WE/ADR/DAT_I in, DAT_O/ACK out)
//   IRQ    out  registered |(FLAG & IE)
// Register map (word address):
//   0 STATUS (W1C flags)   1 CTRL {IE,AUTO,EN}   2 TICKS   3 reserved
//   4+2i LOAD[i]           5+2i CNT[i]           others unmapped (read 0)
// ----------------------------------------------------------------------------
module timer_unit #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned N_CH     = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    timer_unit_if.slave  bus,
    output logic         IRQ
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;

    logic [N_CH-1:0]  flag_q, flag_d, flag_set;
    logic [N_CH-1:0]  en_q, en_d;
    logic [N_CH-1:0]  auto_q, auto_d;
    logic [N_CH-1:0]  ie_q, ie_d;
    logic [31:0]      ticks_q, ticks_d;
    logic [CNT_W-1:0] load_q [N_CH];
    logic [CNT_W-1:0] load_d [N_CH];
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];

    logic             ack_q;
    logic [31:0]      dat_q, rd_val;
    logic             irq_q;

    logic             acc, wr;

    // ACK is high for exactly one cycle after an access, so a held STB
    // only starts a new access every other cycle.
    assign acc = bus.STB & ~ack_q;
    assign wr  = acc & bus.WE;

    assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

    // Read mux: anything not decoded (reserved, unmapped) reads as zero.
    always_comb begin
        rd_val = '0;
        case (bus.ADR)
            5'd0: rd_val[N_CH-1:0] = flag_q;
            5'd1: begin
                rd_val[N_CH-1:0]   = en_q;
                rd_val[8 +: N_CH]  = auto_q;
                rd_val[16 +: N_CH] = ie_q;
            end
            5'd2: rd_val = ticks_q;
            default: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (bus.ADR == 5'(4 + 2 * i)) rd_val = 32'(load_q[i]);
                    if (bus.ADR == 5'(5 + 2 * i)) rd_val = 32'(cnt_q[i]);
                end
            end
        endcase
    end

    // Next-state: tick effects first, bus writes override them, and expiry
    // flags are OR-ed in last so a same-edge set beats a W1C.
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        flag_set = '0;
        en_d     = en_q;
        auto_d   = auto_q;
        ie_d     = ie_q;
        ticks_d  = ticks_q;
        load_d   = load_q;
        cnt_d    = cnt_q;
        flag_d   = flag_q;

        if (tick) ticks_d = ticks_q + 32'd1;

        for (int i = 0; i < N_CH; i++) begin
            if (tick && en_q[i]) begin
                if (cnt_q[i] > CNT_W'(1)) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end else begin
                    flag_set[i] = 1'b1;
                    if (auto_q[i]) begin
                        cnt_d[i] = load_q[i];
                    end else begin
                        cnt_d[i] = '0;
                        en_d[i]  = 1'b0;
                    end
                end
            end
        end

        if (wr) begin
            case (bus.ADR)
                5'd0: flag_d = flag_q & ~bus.DAT_I[N_CH-1:0];
                5'd1: begin
                    en_d   = bus.DAT_I[N_CH-1:0];
                    auto_d = bus.DAT_I[8 +: N_CH];
                    ie_d   = bus.DAT_I[16 +: N_CH];
                end
                5'd2: ticks_d = bus.DAT_I;
                default: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (bus.ADR == 5'(4 + 2 * i)) load_d[i] = bus.DAT_I[CNT_W-1:0];
                        if (bus.ADR == 5'(5 + 2 * i)) begin
                            // A CNT write cancels this edge's decrement or expiry
                            // entirely, including the one-shot EN clear.
                            cnt_d[i]    = bus.DAT_I[CNT_W-1:0];
                            flag_set[i] = 1'b0;
                            en_d[i]     = en_q[i];
                        end
                    end
                end
            endcase
        end

        flag_d = flag_d | flag_set;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            flag_q  <= '0;
            en_q    <= '0;
            auto_q  <= '0;
            ie_q    <= '0;
            ticks_q <= '0;
            // NOTE: the LOAD/CNT arrays are small register files, not RAM, and
            // must come out of reset at zero, so they are reset element-wise.
            for (int i = 0; i < N_CH; i++) begin
                load_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            ack_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            flag_q  <= flag_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            ticks_q <= ticks_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
            ack_q   <= acc;
            // DAT_O carries read data only during the ACK cycle; zero otherwise.
            dat_q   <= (acc && !bus.WE) ? rd_val : '0;
            irq_q   <= |(flag_q & ie_q);
        end
    end

    assign bus.ACK   = ack_q;
    assign bus.DAT_O = dat_q;
    assign IRQ       = irq_q;

endmodule
